// File: rtl/present_pkg.sv
// Shared constants for the PRESENT S-box layer: forward/inverse tables, FSM states, lookup helper.
// Default state width comes from the `SIZE macro (64 if undefined).
`ifndef SIZE
`define SIZE 64
`endif

package present_pkg;

  localparam int unsigned WIDTH = `SIZE;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } slayer_state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] nibble, input logic inv);
    return inv ? SBOX_INV[nibble] : SBOX[nibble];
  endfunction

endpackage

// File: rtl/present_slayer_if.sv
// Start/done handshake bundle for present_slayer.
// The `inverse` request bit exists only when SLAYER_INVERSE_EN is defined.
interface present_slayer_if #(
  parameter int unsigned WIDTH = present_pkg::WIDTH
);

  logic             start;
  logic [WIDTH-1:0] original;
  logic [WIDTH-1:0] substituted;
  logic             busy;
  logic             done;
`ifdef SLAYER_INVERSE_EN
  logic             inverse;
`endif

  modport master (
`ifdef SLAYER_INVERSE_EN
    output inverse,
`endif
    output start,
    output original,
    input  substituted,
    input  busy,
    input  done
  );

  modport slave (
`ifdef SLAYER_INVERSE_EN
    input  inverse,
`endif
    input  start,
    input  original,
    output substituted,
    output busy,
    output done
  );

endinterface

// File: rtl/present_sbox4.sv
// Single 4-bit PRESENT S-box lookup; inv_i selects the inverse table.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       inv_i,
  output logic [3:0] nibble_o
);

  always_comb nibble_o = sbox4(nibble_i, inv_i);

endmodule

// File: rtl/present_slayer.sv
// Iterative PRESENT S-box layer: substitutes NIBBLES_PER_CYCLE nibbles per clock, LSB group first.
// Define SLAYER_INVERSE_EN to add a per-operation inverse S-box selection.
module present_slayer
  import present_pkg::*;
#(
  parameter int unsigned WIDTH             = present_pkg::WIDTH,
  parameter int unsigned NIBBLES_PER_CYCLE = 1
) (
  input logic             Clock,
  input logic             Reset_n,
  present_slayer_if.slave bus
);

  localparam int unsigned GroupW    = 4 * NIBBLES_PER_CYCLE;
  localparam int unsigned NumGroups = WIDTH / GroupW;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;

  if (!(NIBBLES_PER_CYCLE == 1 || NIBBLES_PER_CYCLE == 2 || NIBBLES_PER_CYCLE == 4 ||
        NIBBLES_PER_CYCLE == 8 || NIBBLES_PER_CYCLE == 16)) begin : g_bad_npc
    $error("present_slayer: NIBBLES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  if ((WIDTH % GroupW) != 0 || WIDTH == 0) begin : g_bad_width
    $error("present_slayer: WIDTH must be a non-zero multiple of 4*NIBBLES_PER_CYCLE");
  end

  slayer_state_t    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             inv;

  logic [GroupW-1:0] group_in;
  logic [GroupW-1:0] group_out;

`ifdef SLAYER_INVERSE_EN
  // Direction is latched on accept so mid-operation changes cannot mix tables.
  logic inv_q, inv_d;
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  always_comb group_in = sub_q[int'(cnt_q) * GroupW +: GroupW];

  for (genvar i = 0; i < NIBBLES_PER_CYCLE; i++) begin : g_sbox
    present_sbox4 u_sbox (
      .nibble_i (group_in[4*i +: 4]),
      .inv_i    (inv),
      .nibble_o (group_out[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SLAYER_INVERSE_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          sub_d   = bus.original;
          busy_d  = 1'b1;
`ifdef SLAYER_INVERSE_EN
          inv_d   = bus.inverse;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sub_d[int'(cnt_q) * GroupW +: GroupW] = group_out;
        if (cnt_q == CntW'(NumGroups - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SLAYER_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SLAYER_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.substituted = sub_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_present_slayer.sv
// Self-checking bench: three present_slayer instances (1, 4 and 16 nibbles per cycle) share stimulus
// and are compared against a table-driven whole-word reference model.
module tb_present_slayer;

  localparam logic [3:0] FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] original;
  logic        inverse;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  present_slayer_if #(.WIDTH(64)) bus1 ();
  present_slayer_if #(.WIDTH(64)) bus4 ();
  present_slayer_if #(.WIDTH(64)) bus16 ();

  assign bus1.start     = start;
  assign bus1.original  = original;
  assign bus4.start     = start;
  assign bus4.original  = original;
  assign bus16.start    = start;
  assign bus16.original = original;
`ifdef SLAYER_INVERSE_EN
  assign bus1.inverse  = inverse;
  assign bus4.inverse  = inverse;
  assign bus16.inverse = inverse;
`endif

  present_slayer #(.WIDTH(64), .NIBBLES_PER_CYCLE(1)) u_dut1 (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus1)
  );
  present_slayer #(.WIDTH(64), .NIBBLES_PER_CYCLE(4)) u_dut4 (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus4)
  );
  present_slayer #(.WIDTH(64), .NIBBLES_PER_CYCLE(16)) u_dut16 (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_layer(input logic [63:0] x, input bit inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = inv ? INV[x[i*4 +: 4]] : FWD[x[i*4 +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One full operation on all three instances; c counts posedges after the accept edge.
  task automatic run_op(input logic [63:0] vec, input bit inv, input bit toggle,
                        input string tag, output logic [63:0] res1);
    int lat1 = -1, lat4 = -1, lat16 = -1;
    int busy_cnt = 0, done_cnt = 0, overlap = 0;
    logic [63:0] res4 = '0, res16 = '0, exp;
    res1 = '0;
    exp  = ref_layer(vec, inv);
    @(negedge clk);
    start    = 1'b1;
    original = vec;
    inverse  = inv;
    @(negedge clk);
    start    = 1'b0;
    original = rand64();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (bus1.busy) busy_cnt++;
      if (bus1.busy && bus1.done) overlap++;
      if (bus1.done) begin
        done_cnt++;
        if (lat1 < 0) begin lat1 = c; res1 = bus1.substituted; end
      end
      if (bus4.done && lat4 < 0) begin lat4 = c; res4 = bus4.substituted; end
      if (bus16.done && lat16 < 0) begin lat16 = c; res16 = bus16.substituted; end
      if (toggle) inverse = ~inverse;
    end
    check({tag, ".lat1"}, 64'(lat1), 64'd16);
    check({tag, ".lat4"}, 64'(lat4), 64'd4);
    check({tag, ".lat16"}, 64'(lat16), 64'd1);
    check({tag, ".res1"}, res1, exp);
    check({tag, ".res4"}, res4, exp);
    check({tag, ".res16"}, res16, exp);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd16);
    check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
    check({tag, ".held"}, bus1.substituted, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, a, b;
    int lat, dcount;

    rst_n    = 1'b0;
    start    = 1'b0;
    original = '0;
    inverse  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.sub1", bus1.substituted, 64'h0);
    check("rst.sub16", bus16.substituted, 64'h0);
    check("rst.busy", {bus1.busy, bus4.busy, bus16.busy}, 64'h0);
    check("rst.done", {bus1.done, bus4.done, bus16.done}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed vectors with literal expectations
    run_op(64'h0, 1'b0, 1'b0, "zero", res);
    check("zero.literal", res, 64'hCCCCCCCCCCCCCCCC);
    run_op(64'h0123456789ABCDEF, 1'b0, 1'b0, "ramp", res);
    check("ramp.literal", res, 64'hC56B90AD3EF84712);

    for (int i = 0; i < 4; i++) run_op(rand64(), 1'b0, 1'b1, $sformatf("rnd%0d", i), res);

    // start held through RUN with a new original, then re-accepted in DONE
    a = rand64();
    b = rand64();
    @(negedge clk);
    start    = 1'b1;
    original = a;
    inverse  = 1'b0;
    lat      = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      original = b;
      if (bus1.done) begin lat = c; break; end
    end
    check("hold.lat", 64'(lat), 64'd16);
    check("hold.res", bus1.substituted, ref_layer(a, 1'b0));
    @(negedge clk);
    check("b2b.busy", {63'b0, bus1.busy}, 64'd1);
    check("b2b.done", {63'b0, bus1.done}, 64'd0);
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (bus1.done) begin lat = c; break; end
    end
    check("b2b.lat", 64'(lat), 64'd16);
    check("b2b.res", bus1.substituted, ref_layer(b, 1'b0));
    repeat (20) @(negedge clk);

    // Reset in the middle of RUN
    @(negedge clk);
    start    = 1'b1;
    original = rand64();
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.sub", bus1.substituted, 64'h0);
    check("midrst.busy", {63'b0, bus1.busy}, 64'd0);
    check("midrst.done", {63'b0, bus1.done}, 64'd0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.done || bus4.done || bus16.done) dcount++;
    end
    check("midrst.no_done", 64'(dcount), 64'd0);
    run_op(rand64(), 1'b0, 1'b0, "after_rst", res);

`ifdef SLAYER_INVERSE_EN
    run_op(64'hC56B90AD3EF84712, 1'b1, 1'b1, "inv", res);
    check("inv.literal", res, 64'h0123456789ABCDEF);
    for (int i = 0; i < 3; i++) begin
      a = rand64();
      run_op(a, 1'b1, 1'b1, $sformatf("inv_rnd%0d", i), res);
      check($sformatf("inv_rnd%0d.roundtrip", i), ref_layer(res, 1'b0), a);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
